hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and scheduling controller for the 5-stage MIPS pipeline.
- Takes decoded ID-stage fields (Op/Funct/Rs/Rt) and EX-stage destination info.
- Generates PC/IF-ID stall, IF-ID flush and ID-EX bubble.
- Sequences the shared multi-cycle MULT/DIV unit (owner of HI/LO) through a busy FSM, and keeps a saturating stall-cycle counter.

Parameters:
- MULT_CYCLES, 4, EX cycles a mult/multu occupies the MD unit (>=1)
- DIV_CYCLES, 32, EX cycles a div/divu occupies the MD unit (>=1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ID_Valid  input  1  ID stage holds a real instruction
- ID_Op  input  6  opcode of the ID instruction
- ID_Funct  input  6  funct of the ID instruction
- ID_Rs  input  5  rs of the ID instruction
- ID_Rt  input  5  rt of the ID instruction
- EX_MemRead  input  1  EX instruction is a load
- EX_WriteReg  input  5  EX destination register
- Branch_Taken  input  1  ID-resolved branch is taken
- Jump  input  1  ID instruction is j/jal/jr
- PC_Stall  output  1  hold PC
- IF_ID_Stall  output  1  hold IF/ID register
- IF_ID_Flush  output  1  clear IF/ID (control hazard)
- ID_EX_Flush  output  1  insert bubble into ID/EX
- MD_Start  output  1  one-cycle start pulse to the MD unit
- MD_IsDiv  output  1  qualifies MD_Start: 1 = div/divu, 0 = mult/multu
- MD_Busy  output  1  MD FSM not IDLE
- MD_Done  output  1  one-cycle pulse; the MD unit writes HI/LO this cycle
- Stall_Count  output  32  saturating count of cycles with stall=1

Behaviour:
- Decode classes, all qualified by ID_Valid:
  - is_md: Op=0 and Funct in {0x18, 0x19, 0x1A, 0x1B}.
  - is_hilo: Op=0 and Funct in {0x10, 0x11, 0x12, 0x13}.
  - uses_rt: Op=0, or Op in {0x04, 0x05, 0x2B}.
- load_use = EX_MemRead && EX_WriteReg!=0 && (EX_WriteReg==ID_Rs || (uses_rt && EX_WriteReg==ID_Rt)).
- md_hazard = (is_md || is_hilo) && state!=IDLE.
- stall = load_use || md_hazard (combinational, same cycle).
  - PC_Stall = IF_ID_Stall = ID_EX_Flush = stall.
- IF_ID_Flush = (Branch_Taken || Jump) && !stall. Stall wins and suppresses the flush; the branch re-resolves next cycle.
- MD FSM states:
  - IDLE: if is_md && !load_use, then MD_Start=1 and MD_IsDiv=Funct[1] (same cycle, combinational). Load cnt with DIV_CYCLES-1 or MULT_CYCLES-1 and go to BUSY. Otherwise MD_Start=0, MD_IsDiv=0.
  - BUSY: if cnt==0 go to DONE, else cnt decrements. MD_Busy=1.
  - DONE: MD_Done=1, MD_Busy=1, go to IDLE next cycle. HI/LO reads stall in DONE and issue in IDLE.
- Latency:
  - mult issued at cycle t: MD_Done at t+MULT_CYCLES+1.
  - A dependent mflo stalls through that cycle and issues at t+MULT_CYCLES+2.
- Back-to-back MD ops: the second op stalls until IDLE. Non-MD, non-HI/LO instructions are never stalled by the FSM.
- Stall_Count increments by 1 on each cycle with stall=1 and holds at 0xFFFFFFFF.
- Reset (any state, including mid-BUSY):
  - Next cycle: state=IDLE, cnt=0, Stall_Count=0, MD_Busy=0, MD_Done=0.
  - No MD_Done is emitted for the aborted op.
- With ID_Valid=0, Branch_Taken=0, Jump=0 after reset, all outputs are 0.
- EX_WriteReg=0 never causes a load-use stall.

Test Plan:
- Reset, idle inputs: all outputs 0, Stall_Count=0.
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID add (Op=0) with Rs=9, Rt=8 → stall=1 for 1 cycle, Stall_Count=1. Repeat with ID lw (Op=0x23), Rt=8 → no stall.
- MULT_CYCLES=4: ID mult at t → MD_Start=1, MD_IsDiv=0 at t; MD_Busy at t+1..t+5; MD_Done at t+5. An mflo held in ID stalls t+1..t+5 and issues at t+6; Stall_Count=5.
- Branch: Branch_Taken=1 with no hazard → IF_ID_Flush=1. Same with load_use=1 → IF_ID_Flush=0, stall=1.
- Reset asserted during div BUSY (cnt=20) → IDLE next cycle, MD_Busy=0, no MD_Done pulse. A following div issues immediately.
- Saturation: force 2^32+3 stall cycles, or preload via a test hook → Stall_Count stays 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard and scheduling controller for a 5-stage MIPS pipeline.
//               Detects load-use and HI/LO / multi-cycle-unit hazards, drives
//               the PC / IF-ID stall, IF-ID flush and ID-EX bubble, sequences
//               the shared MULT/DIV unit and keeps a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_Valid,
  input  logic [5:0]  ID_Op,
  input  logic [5:0]  ID_Funct,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteReg,
  input  logic        Branch_Taken,
  input  logic        Jump,
  output logic        PC_Stall,
  output logic        IF_ID_Stall,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MD_Start,
  output logic        MD_IsDiv,
  output logic        MD_Busy,
  output logic        MD_Done,
  output logic [31:0] Stall_Count
);

  // The busy counter only has to hold the larger of the two reload values.
  localparam int C_MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int C_CNT_W      = (C_MAX_CYCLES > 1) ? $clog2(C_MAX_CYCLES) : 1;

  localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES - 1);

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_BNE   = 6'h05;
  localparam logic [5:0] C_OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e            state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]          stall_count_q, stall_count_d;

  logic w_is_md;
  logic w_is_hilo;
  logic w_uses_rt;
  logic w_load_use;
  logic w_md_hazard;
  logic w_stall;

  // Decode the ID instruction and derive the combined pipeline stall.
  always_comb begin
    w_is_md     = 1'b0;
    w_is_hilo   = 1'b0;
    w_uses_rt   = 1'b0;
    w_load_use  = 1'b0;
    w_md_hazard = 1'b0;
    w_stall     = 1'b0;

    w_is_md   = ID_Valid && (ID_Op == C_OP_RTYPE) &&
                (ID_Funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    w_is_hilo = ID_Valid && (ID_Op == C_OP_RTYPE) &&
                (ID_Funct inside {6'h10, 6'h11, 6'h12, 6'h13});
    // Loads and immediates carry their destination in rt, so rt is only a
    // source for R-type, branches that compare rs/rt, and stores.
    w_uses_rt = ID_Valid &&
                ((ID_Op == C_OP_RTYPE) || (ID_Op == C_OP_BEQ) ||
                 (ID_Op == C_OP_BNE)   || (ID_Op == C_OP_SW));

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    w_load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                 ((EX_WriteReg == ID_Rs) || (w_uses_rt && (EX_WriteReg == ID_Rt)));

    // HI/LO readers and new MD ops wait until the unit is back in IDLE,
    // which also holds them through the DONE cycle where HI/LO is written.
    w_md_hazard = (w_is_md || w_is_hilo) && (state_q != MD_IDLE);

    w_stall = w_load_use || w_md_hazard;
  end

  // Pipeline control outputs; a stall suppresses the control-hazard flush.
  always_comb begin
    PC_Stall    = w_stall;
    IF_ID_Stall = w_stall;
    ID_EX_Flush = w_stall;
    IF_ID_Flush = (Branch_Taken || Jump) && !w_stall;
    Stall_Count = stall_count_q;
  end

  // MD unit FSM next-state, busy counter and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    MD_Start = 1'b0;
    MD_IsDiv = 1'b0;
    MD_Busy  = 1'b0;
    MD_Done  = 1'b0;

    case (state_q)
      MD_IDLE: begin
        // Issue only when the op is not itself held back by a load-use stall.
        if (w_is_md && !w_load_use) begin
          MD_Start = 1'b1;
          MD_IsDiv = ID_Funct[1];
          cnt_d    = ID_Funct[1] ? C_DIV_LOAD : C_MULT_LOAD;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        MD_Busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: begin
        MD_Busy = 1'b1;
        MD_Done = 1'b1;
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_count_d = stall_count_q;
    if (w_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // State registers; reset aborts any in-flight MD op without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MD_IDLE;
      cnt_q         <= '0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
`default_nettype wire
